// File: rtl/pal_line_scheduler_pkg.sv
// Shared types and defaults for the PAL line scheduler.
// Holds the phase encoding, line-count width and parameter defaults.
package pal_line_scheduler_pkg;

  typedef enum logic [2:0] {
    PH_WAIT    = 3'd0,
    PH_VSYNC   = 3'd1,
    PH_TOP_PAD = 3'd2,
    PH_ACTIVE  = 3'd3,
    PH_BOT_PAD = 3'd4,
    PH_TAIL    = 3'd5
  } phase_e;

  localparam int LC_W = 9;

  localparam int LINE_CLKS_DEF = 912;
  localparam int HS_CLKS_DEF   = 67;
  localparam int TOP_PAD_DEF   = 25;
  localparam int BOT_PAD_DEF   = 25;
  localparam int BOT_START_DEF = 216;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus edge detector for a raw async level.
// Ports: clk, rst (async, active high), din raw; fall/rise one-clk pulses.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
      fall <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
      fall <= prev & ~s2;
      rise <= ~prev & s2;
    end
  end

endmodule

// File: rtl/pal_line_scheduler.sv
// Dragon PAL line-padding sequencer: holds the VDG and makes synthetic HS.
// Ports: CLK/RST, raw HSn/FSn in; HoldVdg, SynthHSn, Line24, LineCount, FieldStart, Phase out.
module pal_line_scheduler
  import pal_line_scheduler_pkg::*;
#(
  parameter int LINE_CLKS = LINE_CLKS_DEF,
  parameter int HS_CLKS   = HS_CLKS_DEF,
  parameter int TOP_PAD   = TOP_PAD_DEF,
  parameter int BOT_PAD   = BOT_PAD_DEF,
  parameter int BOT_START = BOT_START_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            HSn,
  input  logic            FSn,
  output logic            HoldVdg,
  output logic            SynthHSn,
  output logic            Line24,
  output logic [LC_W-1:0] LineCount,
  output logic            FieldStart,
  output logic [2:0]      Phase
);

  localparam int TW = $clog2(LINE_CLKS);
  localparam logic [TW-1:0] T_LAST = TW'(LINE_CLKS - 1);
  localparam logic [TW-1:0] HS_N = TW'(HS_CLKS);
  localparam logic [LC_W-1:0] TOP_N = LC_W'(TOP_PAD);
  localparam logic [LC_W-1:0] BOT_N = LC_W'(BOT_PAD);
  localparam logic [LC_W-1:0] START_N = LC_W'(BOT_START);
  localparam logic [LC_W-1:0] LC_MAX = '1;

  logic hs_tick;
  logic hs_rise;
  logic fs_fall;
  logic fs_rise;

  sync_edge u_hs (
    .clk  (CLK),
    .rst  (RST),
    .din  (HSn),
    .fall (hs_tick),
    .rise (hs_rise)
  );

  sync_edge u_fs (
    .clk  (CLK),
    .rst  (RST),
    .din  (FSn),
    .fall (fs_fall),
    .rise (fs_rise)
  );

  phase_e          state;
  phase_e          state_n;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_n;
  logic [TW-1:0]   timer_inc;
  logic [LC_W-1:0] cnt_n;
  logic [LC_W-1:0] cnt_inc;
  logic [LC_W-1:0] pad_len;
  logic            wrap;
  logic            hold_n;
  logic            synth_n;

  always_comb begin
    state_n   = state;
    cnt_n     = LineCount;
    timer_n   = timer;
    hold_n    = HoldVdg;
    wrap      = (timer == T_LAST);
    timer_inc = wrap ? '0 : timer + 1'b1;
    cnt_inc   = (LineCount == LC_MAX) ? LineCount : LineCount + 1'b1;
    pad_len   = (state == PH_TOP_PAD) ? TOP_N : BOT_N;
    if (fs_fall) begin
      // field sync beats everything, including a same-cycle HS tick
      state_n = PH_VSYNC;
      cnt_n   = '0;
      hold_n  = 1'b0;
    end else begin
      unique case (state)
        PH_WAIT: state_n = PH_WAIT;
        PH_VSYNC: begin
          if (fs_rise) begin
            cnt_n   = '0;
            timer_n = '0;
            if (TOP_N == '0) begin
              state_n = PH_ACTIVE;
            end else begin
              state_n = PH_TOP_PAD;
              hold_n  = 1'b1;
            end
          end else if (hs_tick) begin
            cnt_n = cnt_inc;
          end
        end
        PH_TOP_PAD, PH_BOT_PAD: begin
          timer_n = timer_inc;
          if (wrap) begin
            if (cnt_inc == pad_len) begin
              state_n = (state == PH_TOP_PAD) ? PH_ACTIVE : PH_TAIL;
              cnt_n   = '0;
              timer_n = '0;
              hold_n  = 1'b0;
            end else begin
              cnt_n = cnt_inc;
            end
          end
        end
        PH_ACTIVE: begin
          if (LineCount == START_N) begin
            cnt_n   = '0;
            timer_n = '0;
            if (BOT_N == '0) begin
              state_n = PH_TAIL;
            end else begin
              state_n = PH_BOT_PAD;
              hold_n  = 1'b1;
            end
          end else if (hs_tick) begin
            cnt_n = cnt_inc;
          end
        end
        PH_TAIL: if (hs_tick) cnt_n = cnt_inc;
        default: state_n = PH_WAIT;
      endcase
    end
    // look at the next timer so the first low cycle lines up with hold rising
    synth_n = ~(hold_n & (timer_n < HS_N));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= PH_WAIT;
      LineCount  <= '0;
      timer      <= '0;
      HoldVdg    <= 1'b0;
      SynthHSn   <= 1'b1;
      Line24     <= 1'b1;
      FieldStart <= 1'b0;
    end else begin
      state      <= state_n;
      LineCount  <= cnt_n;
      timer      <= timer_n;
      HoldVdg    <= hold_n;
      SynthHSn   <= synth_n;
      Line24     <= ~((state == PH_VSYNC) && (LineCount[4:3] == 2'b11));
      FieldStart <= fs_fall;
    end
  end

  assign Phase = state;

endmodule

// File: tb/tb_pal_line_scheduler.sv
// Directed bench for pal_line_scheduler: default instance plus a short-line
// instance with no top pad for the skip and abort cases.
module tb_pal_line_scheduler;

  logic       clk;
  logic       rst;
  logic       hs_a, fs_a, hs_b, fs_b;
  logic       hold_a, synth_a, l24_a, fst_a;
  logic       hold_b, synth_b, l24_b, fst_b;
  logic [8:0] lc_a, lc_b;
  logic [2:0] ph_a, ph_b;

  int checks = 0;
  int errors = 0;

  pal_line_scheduler u_a (
    .CLK        (clk),
    .RST        (rst),
    .HSn        (hs_a),
    .FSn        (fs_a),
    .HoldVdg    (hold_a),
    .SynthHSn   (synth_a),
    .Line24     (l24_a),
    .LineCount  (lc_a),
    .FieldStart (fst_a),
    .Phase      (ph_a)
  );

  pal_line_scheduler #(
    .LINE_CLKS (40),
    .HS_CLKS   (5),
    .TOP_PAD   (0),
    .BOT_PAD   (25),
    .BOT_START (4)
  ) u_b (
    .CLK        (clk),
    .RST        (rst),
    .HSn        (hs_b),
    .FSn        (fs_b),
    .HoldVdg    (hold_b),
    .SynthHSn   (synth_b),
    .Line24     (l24_b),
    .LineCount  (lc_b),
    .FieldStart (fst_b),
    .Phase      (ph_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_a(input int n);
    for (int k = 0; k < n; k++) begin
      hs_a = 1'b0;
      repeat (4) @(negedge clk);
      hs_a = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic pulse_b(input int n);
    for (int k = 0; k < n; k++) begin
      hs_b = 1'b0;
      repeat (4) @(negedge clk);
      hs_b = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  int  fcnt;
  int  hcnt;
  int  lowcnt;
  int  falls;
  int  perr;
  int  lc_mid;
  int  wcnt;
  bit  prev_s;
  bit  hseen;
  bit  found;

  initial begin
    rst  = 1'b1;
    hs_a = 1'b1;
    fs_a = 1'b1;
    hs_b = 1'b1;
    fs_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_phase", 32'(ph_a), 0);
    chk("rst_count", 32'(lc_a), 0);
    chk("rst_hold", 32'(hold_a), 0);
    chk("rst_synth", 32'(synth_a), 1);
    chk("rst_line24", 32'(l24_a), 1);
    chk("rst_fstart", 32'(fst_a), 0);
    rst = 1'b0;

    pulse_a(10);
    chk("wait_phase", 32'(ph_a), 0);
    chk("wait_count", 32'(lc_a), 0);
    chk("wait_hold", 32'(hold_a), 0);

    fs_a = 1'b0;
    fcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (fst_a) fcnt++;
    end
    chk("fs1_pulses", 32'(fcnt), 1);
    chk("fs1_phase", 32'(ph_a), 1);
    chk("fs1_count", 32'(lc_a), 0);

    pulse_a(24);
    chk("vs24_count", 32'(lc_a), 24);
    chk("vs24_line24", 32'(l24_a), 0);
    pulse_a(1);
    chk("vs25_count", 32'(lc_a), 25);
    chk("vs25_line24", 32'(l24_a), 0);
    pulse_a(6);
    chk("vs31_line24", 32'(l24_a), 0);
    pulse_a(1);
    chk("vs32_count", 32'(lc_a), 32);
    chk("vs32_line24", 32'(l24_a), 1);

    fs_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("top_hold_early", 32'(hold_a), 0);
    @(negedge clk);
    chk("top_hold_rise", 32'(hold_a), 1);
    chk("top_synth_low", 32'(synth_a), 0);
    chk("top_phase", 32'(ph_a), 2);
    chk("top_count0", 32'(lc_a), 0);
    hcnt = 0; lowcnt = 0; falls = 0; perr = 0; lc_mid = -1; prev_s = 1'b1;
    for (int i = 0; i < 25 * 912 + 20; i++) begin
      if (hold_a) hcnt++;
      if (!synth_a) begin
        lowcnt++;
        if (!hold_a) perr++;
      end
      if (!synth_a && prev_s) begin
        falls++;
        if (i % 912 != 0) perr++;
      end
      if (i == 9125) lc_mid = 32'(lc_a);
      prev_s = synth_a;
      @(negedge clk);
    end
    chk("top_hold_cycles", 32'(hcnt), 25 * 912);
    chk("top_synth_pulses", 32'(falls), 25);
    chk("top_synth_low", 32'(lowcnt), 25 * 67);
    chk("top_period_err", 32'(perr), 0);
    chk("top_mid_count", 32'(lc_mid), 10);
    chk("act_phase", 32'(ph_a), 3);
    chk("act_count0", 32'(lc_a), 0);

    pulse_a(215);
    chk("act215_count", 32'(lc_a), 215);
    chk("act215_phase", 32'(ph_a), 3);
    pulse_a(1);
    chk("bot_phase", 32'(ph_a), 4);
    chk("bot_hold", 32'(hold_a), 1);
    chk("bot_count0", 32'(lc_a), 0);
    hcnt = 0;
    while (hold_a && hcnt < 30000) begin
      hcnt++;
      @(negedge clk);
    end
    chk("bot_hold_cycles", 32'(hcnt), 25 * 912 - 3);
    chk("tail_phase", 32'(ph_a), 5);
    chk("tail_count0", 32'(lc_a), 0);
    chk("tail_synth", 32'(synth_a), 1);

    pulse_a(3);
    chk("tail_count3", 32'(lc_a), 3);

    hs_a = 1'b0;
    fs_a = 1'b0;
    fcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (fst_a) fcnt++;
      hs_a = 1'b1;
    end
    chk("same_phase", 32'(ph_a), 1);
    chk("same_count", 32'(lc_a), 0);
    chk("same_fstart", 32'(fcnt), 1);
    pulse_a(1);
    chk("vs_after_count", 32'(lc_a), 1);

    hs_a = 1'b0;
    fs_a = 1'b1;
    repeat (4) @(negedge clk);
    chk("rise_tick_phase", 32'(ph_a), 2);
    chk("rise_tick_count", 32'(lc_a), 0);
    chk("rise_tick_hold", 32'(hold_a), 1);
    hs_a = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hold", 32'(hold_a), 0);
    chk("async_rst_phase", 32'(ph_a), 0);
    @(negedge clk);
    rst = 1'b0;

    fs_b = 1'b0;
    repeat (8) @(negedge clk);
    chk("b_vsync", 32'(ph_b), 1);
    fs_b = 1'b1;
    hseen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      hseen |= hold_b;
    end
    chk("b_skip_hold", 32'(hseen), 0);
    chk("b_skip_phase", 32'(ph_b), 3);
    pulse_b(4);
    chk("b_bot_phase", 32'(ph_b), 4);
    found = 1'b0;
    wcnt = 0;
    while (!found && wcnt < 2000) begin
      if (lc_b == 9'd10) found = 1'b1;
      else begin
        wcnt++;
        @(negedge clk);
      end
    end
    chk("b_reach_line10", 32'(found), 1);
    chk("b_hold_line10", 32'(hold_b), 1);
    fs_b = 1'b0;
    fcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (fst_b) fcnt++;
    end
    chk("b_abort_hold", 32'(hold_b), 0);
    chk("b_abort_synth", 32'(synth_b), 1);
    repeat (4) begin
      @(negedge clk);
      if (fst_b) fcnt++;
    end
    chk("b_abort_fstart", 32'(fcnt), 1);
    chk("b_abort_count", 32'(lc_b), 0);
    chk("b_abort_phase", 32'(ph_b), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
